// File: rtl/axi_mem_arbiter.sv
// Two-master to one-slave AXI-lite arbiter: I/D cache reads share the read path
// round-robin, D-cache writes use an independent write path. One outstanding op per path.
module axi_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                I_AR_VALID,
  input  logic [ADDR_W-1:0]   I_AR_ADDR,
  output logic                I_AR_READY,
  output logic                I_R_VALID,
  output logic [DATA_W-1:0]   I_R_DATA,
  input  logic                I_R_READY,
  input  logic                D_AR_VALID,
  input  logic [ADDR_W-1:0]   D_AR_ADDR,
  output logic                D_AR_READY,
  output logic                D_R_VALID,
  output logic [DATA_W-1:0]   D_R_DATA,
  input  logic                D_R_READY,
  input  logic                D_AW_VALID,
  input  logic [ADDR_W-1:0]   D_AW_ADDR,
  output logic                D_AW_READY,
  input  logic                D_W_VALID,
  input  logic [DATA_W-1:0]   D_W_DATA,
  input  logic [DATA_W/8-1:0] D_W_STRB,
  output logic                D_W_READY,
  output logic                D_B_VALID,
  input  logic                D_B_READY,
  output logic                M_AR_VALID,
  output logic [ADDR_W-1:0]   M_AR_ADDR,
  input  logic                M_AR_READY,
  input  logic                M_R_VALID,
  input  logic [DATA_W-1:0]   M_R_DATA,
  output logic                M_R_READY,
  output logic                M_AW_VALID,
  output logic [ADDR_W-1:0]   M_AW_ADDR,
  input  logic                M_AW_READY,
  output logic                M_W_VALID,
  output logic [DATA_W-1:0]   M_W_DATA,
  output logic [DATA_W/8-1:0] M_W_STRB,
  input  logic                M_W_READY,
  input  logic                M_B_VALID,
  output logic                M_B_READY
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  r_state_t            r_state_reg, r_state_next;
  logic                grant_i_reg, grant_i_next;   // 1 = I-cache owns the read path
  logic                last_i_reg, last_i_next;     // 1 = last completed read was I
  logic [ADDR_W-1:0]   ar_addr_reg, ar_addr_next;

  w_state_t            w_state_reg, w_state_next;
  logic [ADDR_W-1:0]   aw_addr_reg, aw_addr_next;
  logic [DATA_W-1:0]   w_data_reg, w_data_next;
  logic [STRB_W-1:0]   w_strb_reg, w_strb_next;
  logic                aw_done_reg, aw_done_next;
  logic                w_done_reg, w_done_next;

  logic                r_data_phase;
  logic [1:0]          r_sel;
  logic [1:0]          r_ready_up;
  logic [1:0]          r_valid_up;
  logic [DATA_W-1:0]   r_data_up [2];

  // ---------------- read path ----------------
  always_comb begin
    r_state_next = r_state_reg;
    grant_i_next = grant_i_reg;
    last_i_next  = last_i_reg;
    ar_addr_next = ar_addr_reg;
    I_AR_READY   = 1'b0;
    D_AR_READY   = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        // Readies are gated by reset so nothing looks accepted while it is held.
        if (!ARESET && (I_AR_VALID || D_AR_VALID)) begin
          if (I_AR_VALID && (!D_AR_VALID || !last_i_reg)) begin
            I_AR_READY   = 1'b1;
            grant_i_next = 1'b1;
            ar_addr_next = I_AR_ADDR;
          end else begin
            D_AR_READY   = 1'b1;
            grant_i_next = 1'b0;
            ar_addr_next = D_AR_ADDR;
          end
          r_state_next = R_ADDR;
        end
      end
      R_ADDR: if (M_AR_READY) r_state_next = R_DATA;
      R_DATA: begin
        if (M_R_VALID && M_R_READY) begin
          last_i_next  = grant_i_reg;
          r_state_next = R_IDLE;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign M_AR_VALID   = (r_state_reg == R_ADDR);
  assign M_AR_ADDR    = ar_addr_reg;
  assign r_data_phase = (r_state_reg == R_DATA);
  assign r_sel        = {!grant_i_reg, grant_i_reg};
  assign r_ready_up   = {D_R_READY, I_R_READY};
  assign M_R_READY    = r_data_phase && |(r_sel & r_ready_up);

  // Index 0 is the I-cache, index 1 the D-cache; only the owner sees read data.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_r_route
      logic sel_here;
      assign sel_here       = r_data_phase && r_sel[gi];
      assign r_valid_up[gi] = sel_here && M_R_VALID;
      assign r_data_up[gi]  = sel_here ? M_R_DATA : '0;
    end
  endgenerate

  assign I_R_VALID = r_valid_up[0];
  assign D_R_VALID = r_valid_up[1];
  assign I_R_DATA  = r_data_up[0];
  assign D_R_DATA  = r_data_up[1];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_reg <= R_IDLE;
      grant_i_reg <= 1'b0;
      last_i_reg  <= 1'b0;
      ar_addr_reg <= '0;
    end else begin
      r_state_reg <= r_state_next;
      grant_i_reg <= grant_i_next;
      last_i_reg  <= last_i_next;
      ar_addr_reg <= ar_addr_next;
    end
  end

  // ---------------- write path ----------------
  assign D_AW_READY = !ARESET && (w_state_reg == W_IDLE) && D_AW_VALID && D_W_VALID;
  assign D_W_READY  = D_AW_READY;
  assign M_AW_VALID = (w_state_reg == W_SEND) && !aw_done_reg;
  assign M_W_VALID  = (w_state_reg == W_SEND) && !w_done_reg;
  assign M_AW_ADDR  = aw_addr_reg;
  assign M_W_DATA   = w_data_reg;
  assign M_W_STRB   = w_strb_reg;
  assign D_B_VALID  = (w_state_reg == W_RESP) && M_B_VALID;
  assign M_B_READY  = (w_state_reg == W_RESP) && D_B_READY;

  always_comb begin
    w_state_next = w_state_reg;
    aw_addr_next = aw_addr_reg;
    w_data_next  = w_data_reg;
    w_strb_next  = w_strb_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    case (w_state_reg)
      W_IDLE: begin
        if (D_AW_READY) begin
          aw_addr_next = D_AW_ADDR;
          w_data_next  = D_W_DATA;
          w_strb_next  = D_W_STRB;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          w_state_next = W_SEND;
        end
      end
      W_SEND: begin
        aw_done_next = aw_done_reg || (M_AW_VALID && M_AW_READY);
        w_done_next  = w_done_reg || (M_W_VALID && M_W_READY);
        if (aw_done_next && w_done_next) w_state_next = W_RESP;
      end
      W_RESP: if (M_B_VALID && D_B_READY) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_reg <= W_IDLE;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      aw_addr_reg <= aw_addr_next;
      w_data_reg  <= w_data_next;
      w_strb_reg  <= w_strb_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: the bench plays both caches and the memory slave.
module tb_axi_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic I_AR_VALID, I_AR_READY, I_R_VALID, I_R_READY;
  logic [ADDR_W-1:0] I_AR_ADDR;
  logic [DATA_W-1:0] I_R_DATA;
  logic D_AR_VALID, D_AR_READY, D_R_VALID, D_R_READY;
  logic [ADDR_W-1:0] D_AR_ADDR;
  logic [DATA_W-1:0] D_R_DATA;
  logic D_AW_VALID, D_AW_READY, D_W_VALID, D_W_READY, D_B_VALID, D_B_READY;
  logic [ADDR_W-1:0] D_AW_ADDR;
  logic [DATA_W-1:0] D_W_DATA;
  logic [DATA_W/8-1:0] D_W_STRB;
  logic M_AR_VALID, M_AR_READY, M_R_VALID, M_R_READY;
  logic [ADDR_W-1:0] M_AR_ADDR;
  logic [DATA_W-1:0] M_R_DATA;
  logic M_AW_VALID, M_AW_READY, M_W_VALID, M_W_READY, M_B_VALID, M_B_READY;
  logic [ADDR_W-1:0] M_AW_ADDR;
  logic [DATA_W-1:0] M_W_DATA;
  logic [DATA_W/8-1:0] M_W_STRB;

  int total = 0;
  int bad = 0;

  axi_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .I_AR_VALID(I_AR_VALID), .I_AR_ADDR(I_AR_ADDR), .I_AR_READY(I_AR_READY),
    .I_R_VALID(I_R_VALID), .I_R_DATA(I_R_DATA), .I_R_READY(I_R_READY),
    .D_AR_VALID(D_AR_VALID), .D_AR_ADDR(D_AR_ADDR), .D_AR_READY(D_AR_READY),
    .D_R_VALID(D_R_VALID), .D_R_DATA(D_R_DATA), .D_R_READY(D_R_READY),
    .D_AW_VALID(D_AW_VALID), .D_AW_ADDR(D_AW_ADDR), .D_AW_READY(D_AW_READY),
    .D_W_VALID(D_W_VALID), .D_W_DATA(D_W_DATA), .D_W_STRB(D_W_STRB), .D_W_READY(D_W_READY),
    .D_B_VALID(D_B_VALID), .D_B_READY(D_B_READY),
    .M_AR_VALID(M_AR_VALID), .M_AR_ADDR(M_AR_ADDR), .M_AR_READY(M_AR_READY),
    .M_R_VALID(M_R_VALID), .M_R_DATA(M_R_DATA), .M_R_READY(M_R_READY),
    .M_AW_VALID(M_AW_VALID), .M_AW_ADDR(M_AW_ADDR), .M_AW_READY(M_AW_READY),
    .M_W_VALID(M_W_VALID), .M_W_DATA(M_W_DATA), .M_W_STRB(M_W_STRB), .M_W_READY(M_W_READY),
    .M_B_VALID(M_B_VALID), .M_B_READY(M_B_READY)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    I_AR_VALID = 0; I_AR_ADDR = '0; I_R_READY = 0;
    D_AR_VALID = 0; D_AR_ADDR = '0; D_R_READY = 0;
    D_AW_VALID = 0; D_AW_ADDR = '0; D_W_VALID = 0; D_W_DATA = '0; D_W_STRB = '0; D_B_READY = 0;
    M_AR_READY = 0; M_R_VALID = 0; M_R_DATA = '0;
    M_AW_READY = 0; M_W_READY = 0; M_B_VALID = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    ARESET = 1;
    I_AR_VALID = 1; D_AR_VALID = 1; D_AW_VALID = 1; D_W_VALID = 1;
    tick(); tick();
    total++; if (I_AR_READY !== 1'b0) begin bad++; $display("FAIL rst_i_ar_ready got=%b exp=0", I_AR_READY); end
    total++; if (D_AR_READY !== 1'b0) begin bad++; $display("FAIL rst_d_ar_ready got=%b exp=0", D_AR_READY); end
    total++; if ({D_AW_READY, D_W_READY} !== 2'b00) begin bad++; $display("FAIL rst_w_readies got=%b exp=00", {D_AW_READY, D_W_READY}); end
    total++; if ({M_AR_VALID, M_AW_VALID, M_W_VALID, I_R_VALID, D_R_VALID, D_B_VALID} !== 6'b0) begin bad++; $display("FAIL rst_valids got=%b exp=000000", {M_AR_VALID, M_AW_VALID, M_W_VALID, I_R_VALID, D_R_VALID, D_B_VALID}); end
    total++; if ({M_AR_ADDR, M_AW_ADDR, M_W_DATA, M_W_STRB} !== '0) begin bad++; $display("FAIL rst_buses got=%h exp=0", {M_AR_ADDR, M_AW_ADDR, M_W_DATA, M_W_STRB}); end
    clear_inputs();
    #1 ARESET = 0;
    tick();
    $display("reset released");
  endtask

  task automatic test_single_read();
    I_AR_VALID = 1; I_AR_ADDR = 32'h100; I_R_READY = 1;
    #1;
    total++; if (I_AR_READY !== 1'b1) begin bad++; $display("FAIL t1_i_ar_ready got=%b exp=1", I_AR_READY); end
    total++; if (M_AR_VALID !== 1'b0) begin bad++; $display("FAIL t1_m_ar_valid_c0 got=%b exp=0", M_AR_VALID); end
    tick();
    I_AR_VALID = 0;
    #1;
    total++; if (M_AR_VALID !== 1'b1) begin bad++; $display("FAIL t1_m_ar_valid_c1 got=%b exp=1", M_AR_VALID); end
    total++; if (M_AR_ADDR !== 32'h100) begin bad++; $display("FAIL t1_m_ar_addr got=%h exp=100", M_AR_ADDR); end
    M_AR_READY = 1;
    tick();
    M_AR_READY = 0; M_R_VALID = 1; M_R_DATA = 32'hDEADBEEF;
    #1;
    total++; if (I_R_VALID !== 1'b1) begin bad++; $display("FAIL t1_i_r_valid got=%b exp=1", I_R_VALID); end
    total++; if (I_R_DATA !== 32'hDEADBEEF) begin bad++; $display("FAIL t1_i_r_data got=%h exp=deadbeef", I_R_DATA); end
    total++; if (D_R_VALID !== 1'b0) begin bad++; $display("FAIL t1_d_r_valid got=%b exp=0", D_R_VALID); end
    total++; if (M_R_READY !== 1'b1) begin bad++; $display("FAIL t1_m_r_ready got=%b exp=1", M_R_READY); end
    total++; if (M_AR_VALID !== 1'b0) begin bad++; $display("FAIL t1_m_ar_valid_drop got=%b exp=0", M_AR_VALID); end
    tick();
    M_R_VALID = 0; M_R_DATA = '0;
    #1;
    total++; if (I_R_VALID !== 1'b0) begin bad++; $display("FAIL t1_i_r_valid_end got=%b exp=0", I_R_VALID); end
    $display("read I addr=100 data=%h", I_R_DATA);
  endtask

  task automatic test_round_robin();
    logic exp_i;
    logic [DATA_W-1:0] exp_data, got_own, got_other;
    logic got_own_v, got_other_v;
    ARESET = 1;
    #1 ARESET = 0;
    I_AR_VALID = 1; I_AR_ADDR = 32'h200; I_R_READY = 1;
    D_AR_VALID = 1; D_AR_ADDR = 32'h8000; D_R_READY = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_i = (k % 2 == 0);
      exp_data = 32'hA0000000 + k;
      total++; if ({I_AR_READY, D_AR_READY} !== {exp_i, !exp_i}) begin bad++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, {I_AR_READY, D_AR_READY}, {exp_i, !exp_i}); end
      tick();
      total++; if (M_AR_ADDR !== (exp_i ? 32'h200 : 32'h8000) || M_AR_VALID !== 1'b1) begin bad++; $display("FAIL rr_m_ar k=%0d got=%b/%h", k, M_AR_VALID, M_AR_ADDR); end
      total++; if ({I_AR_READY, D_AR_READY} !== 2'b00) begin bad++; $display("FAIL rr_ar_ready_busy k=%0d got=%b exp=00", k, {I_AR_READY, D_AR_READY}); end
      M_AR_READY = 1;
      tick();
      M_AR_READY = 0; M_R_VALID = 1; M_R_DATA = exp_data;
      #1;
      got_own_v   = exp_i ? I_R_VALID : D_R_VALID;
      got_other_v = exp_i ? D_R_VALID : I_R_VALID;
      got_own     = exp_i ? I_R_DATA : D_R_DATA;
      got_other   = exp_i ? D_R_DATA : I_R_DATA;
      total++; if ({got_own_v, got_other_v} !== 2'b10) begin bad++; $display("FAIL rr_r_valid k=%0d got=%b exp=10", k, {got_own_v, got_other_v}); end
      total++; if (got_own !== exp_data || got_other !== '0) begin bad++; $display("FAIL rr_r_data k=%0d got=%h/%h exp=%h/0", k, got_own, got_other, exp_data); end
      $display("read %s data=%h", exp_i ? "I" : "D", got_own);
      tick();
      M_R_VALID = 0;
      #1;
    end
    I_AR_VALID = 0; D_AR_VALID = 0;
  endtask

  task automatic test_write_accept();
    D_AW_VALID = 1; D_AW_ADDR = 32'h8004; D_W_VALID = 0;
    D_W_DATA = 32'h12345678; D_W_STRB = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if ({D_AW_READY, D_W_READY} !== 2'b00) begin bad++; $display("FAIL wa_aw_only c=%0d got=%b exp=00", c, {D_AW_READY, D_W_READY}); end
      tick();
    end
    D_W_VALID = 1;
    #1;
    total++; if ({D_AW_READY, D_W_READY} !== 2'b11) begin bad++; $display("FAIL wa_both_ready got=%b exp=11", {D_AW_READY, D_W_READY}); end
    tick();
    D_AW_VALID = 0; D_W_VALID = 0; D_W_DATA = '0; D_W_STRB = '0;
    #1;
    total++; if ({M_AW_VALID, M_W_VALID} !== 2'b11) begin bad++; $display("FAIL wa_m_valids got=%b exp=11", {M_AW_VALID, M_W_VALID}); end
    total++; if (M_AW_ADDR !== 32'h8004) begin bad++; $display("FAIL wa_m_aw_addr got=%h exp=8004", M_AW_ADDR); end
    total++; if (M_W_DATA !== 32'h12345678 || M_W_STRB !== 4'hF) begin bad++; $display("FAIL wa_m_w got=%h/%h exp=12345678/f", M_W_DATA, M_W_STRB); end
    total++; if (D_AW_READY !== 1'b0) begin bad++; $display("FAIL wa_ready_busy got=%b exp=0", D_AW_READY); end
  endtask

  task automatic test_write_order();
    M_W_READY = 1;
    tick();
    M_W_READY = 0; M_B_VALID = 1;
    #1;
    total++; if ({M_AW_VALID, M_W_VALID} !== 2'b10) begin bad++; $display("FAIL wo_after_w got=%b exp=10", {M_AW_VALID, M_W_VALID}); end
    total++; if (D_B_VALID !== 1'b0) begin bad++; $display("FAIL wo_b_early1 got=%b exp=0", D_B_VALID); end
    tick();
    M_AW_READY = 1;
    #1;
    total++; if (M_AW_VALID !== 1'b1 || D_B_VALID !== 1'b0) begin bad++; $display("FAIL wo_aw_hold got=%b/%b exp=1/0", M_AW_VALID, D_B_VALID); end
    tick();
    M_AW_READY = 0;
    #1;
    total++; if (M_AW_VALID !== 1'b0) begin bad++; $display("FAIL wo_aw_drop got=%b exp=0", M_AW_VALID); end
    total++; if ({D_B_VALID, M_B_READY} !== 2'b10) begin bad++; $display("FAIL wo_resp_stall got=%b exp=10", {D_B_VALID, M_B_READY}); end
    tick();
    total++; if ({D_B_VALID, M_B_READY} !== 2'b10) begin bad++; $display("FAIL wo_resp_hold got=%b exp=10", {D_B_VALID, M_B_READY}); end
    D_B_READY = 1;
    #1;
    total++; if (M_B_READY !== 1'b1) begin bad++; $display("FAIL wo_b_ready got=%b exp=1", M_B_READY); end
    tick();
    M_B_VALID = 0; D_B_READY = 0;
    #1;
    total++; if (D_B_VALID !== 1'b0) begin bad++; $display("FAIL wo_b_done got=%b exp=0", D_B_VALID); end
    $display("write addr=8004 data=12345678 strb=f");
  endtask

  task automatic test_concurrent();
    I_AR_VALID = 1; I_AR_ADDR = 32'h300; I_R_READY = 1;
    D_AW_VALID = 1; D_AW_ADDR = 32'h9000; D_W_VALID = 1; D_W_DATA = 32'hCAFEF00D; D_W_STRB = 4'h3;
    #1;
    total++; if ({I_AR_READY, D_AW_READY} !== 2'b11) begin bad++; $display("FAIL cc_accept got=%b exp=11", {I_AR_READY, D_AW_READY}); end
    tick();
    I_AR_VALID = 0; D_AW_VALID = 0; D_W_VALID = 0;
    M_AR_READY = 1; M_AW_READY = 1;
    #1;
    total++; if ({M_AR_VALID, M_AW_VALID, M_W_VALID} !== 3'b111) begin bad++; $display("FAIL cc_m_valids got=%b exp=111", {M_AR_VALID, M_AW_VALID, M_W_VALID}); end
    total++; if (M_AW_ADDR !== 32'h9000 || M_W_STRB !== 4'h3) begin bad++; $display("FAIL cc_m_aw got=%h/%h exp=9000/3", M_AW_ADDR, M_W_STRB); end
    tick();
    M_AR_READY = 0; M_AW_READY = 0; M_R_VALID = 1; M_R_DATA = 32'h55AA55AA;
    #1;
    total++; if (I_R_VALID !== 1'b1 || I_R_DATA !== 32'h55AA55AA) begin bad++; $display("FAIL cc_i_r got=%b/%h exp=1/55aa55aa", I_R_VALID, I_R_DATA); end
    total++; if ({M_AW_VALID, M_W_VALID} !== 2'b01) begin bad++; $display("FAIL cc_w_pending got=%b exp=01", {M_AW_VALID, M_W_VALID}); end
    M_W_READY = 1;
    tick();
    M_R_VALID = 0; M_W_READY = 0; M_B_VALID = 1; D_B_READY = 1;
    #1;
    total++; if ({D_B_VALID, M_B_READY, I_R_VALID} !== 3'b110) begin bad++; $display("FAIL cc_resp got=%b exp=110", {D_B_VALID, M_B_READY, I_R_VALID}); end
    tick();
    M_B_VALID = 0; D_B_READY = 0;
    #1;
    total++; if (D_B_VALID !== 1'b0) begin bad++; $display("FAIL cc_b_done got=%b exp=0", D_B_VALID); end
    $display("read I data=55aa55aa overlapped write addr=9000");
  endtask

  task automatic test_reset_mid();
    I_AR_VALID = 1; I_AR_ADDR = 32'h400; I_R_READY = 1;
    D_AW_VALID = 1; D_AW_ADDR = 32'hA000; D_W_VALID = 1; D_W_DATA = 32'h77778888; D_W_STRB = 4'hC;
    tick();
    I_AR_VALID = 0; D_AW_VALID = 0; D_W_VALID = 0;
    M_AR_READY = 1;
    tick();
    M_AR_READY = 0; M_R_VALID = 1; M_R_DATA = 32'h11112222;
    #1;
    total++; if ({I_R_VALID, M_AW_VALID, M_W_VALID} !== 3'b111) begin bad++; $display("FAIL rm_before got=%b exp=111", {I_R_VALID, M_AW_VALID, M_W_VALID}); end
    ARESET = 1;
    #1;
    total++; if ({I_R_VALID, M_R_READY, M_AR_VALID, M_AW_VALID, M_W_VALID} !== 5'b0) begin bad++; $display("FAIL rm_valids got=%b exp=00000", {I_R_VALID, M_R_READY, M_AR_VALID, M_AW_VALID, M_W_VALID}); end
    total++; if ({I_R_DATA, M_AR_ADDR, M_AW_ADDR, M_W_DATA, M_W_STRB} !== '0) begin bad++; $display("FAIL rm_buses got=%h exp=0", {I_R_DATA, M_AR_ADDR, M_AW_ADDR, M_W_DATA, M_W_STRB}); end
    clear_inputs();
    tick();
    #1 ARESET = 0;
    I_AR_VALID = 1; I_AR_ADDR = 32'h500; I_R_READY = 1;
    D_AR_VALID = 1; D_AR_ADDR = 32'h8800;
    #1;
    total++; if ({I_AR_READY, D_AR_READY} !== 2'b10) begin bad++; $display("FAIL rm_tie got=%b exp=10", {I_AR_READY, D_AR_READY}); end
    tick();
    I_AR_VALID = 0; D_AR_VALID = 0;
    #1;
    total++; if (M_AR_VALID !== 1'b1 || M_AR_ADDR !== 32'h500) begin bad++; $display("FAIL rm_m_ar got=%b/%h exp=1/500", M_AR_VALID, M_AR_ADDR); end
    M_AR_READY = 1;
    tick();
    M_AR_READY = 0; M_R_VALID = 1; M_R_DATA = 32'h0BADF00D;
    #1;
    total++; if (I_R_VALID !== 1'b1 || I_R_DATA !== 32'h0BADF00D) begin bad++; $display("FAIL rm_i_r got=%b/%h exp=1/0badf00d", I_R_VALID, I_R_DATA); end
    tick();
    M_R_VALID = 0;
    $display("read I addr=500 after mid-transaction reset");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_accept();
    test_write_order();
    test_concurrent();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
